// File: rtl/sram_bist_ctrl.sv
// sram_bist_ctrl: March C- BIST controller driving the A_BIST_* port group of a single-port SRAM macro.
module sram_bist_ctrl #(
    parameter int unsigned       ADDR_W       = 6,
    parameter int unsigned       DATA_W       = 64,
    parameter logic [DATA_W-1:0] BG           = '0,
    parameter bit                STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              bist_en,
    output logic              bist_men,
    output logic              bist_wen,
    output logic              bist_ren,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_din,
    output logic [DATA_W-1:0] bist_bm,
    input  logic [DATA_W-1:0] bist_dout
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] ONE = 1;
    state_t state_q, state_d;
    logic [2:0] elem_q, elem_d, chk_elem_q, chk_elem_d, fail_elem_q, fail_elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d, baddr_q, baddr_d, chk_addr_q, chk_addr_d, fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] din_q, din_d, bm_q, bm_d, exp_q, exp_d;
    logic ph_q, ph_d, en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
    logic chk_q, chk_d, fail_q, fail_d;
    logic two_op, down, last_addr, mism, run, rd;
    always_comb begin
        two_op = elem_q != 3'd0 && elem_q != 3'd5;
        down = elem_q == 3'd3 || elem_q == 3'd4;
        last_addr = down ? (addr_q == '0) : (&addr_q);
        mism = (state_q == RUN || state_q == DRAIN) && chk_q && (bist_dout != exp_q);
        state_d = state_q;
        elem_d = elem_q;
        addr_d = addr_q;
        ph_d = ph_q;
        fail_d = fail_q | mism;
        fail_addr_d = (mism && !fail_q) ? chk_addr_q : fail_addr_q;
        fail_elem_d = (mism && !fail_q) ? chk_elem_q : fail_elem_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = RUN;
                elem_d = '0;
                addr_d = '0;
                ph_d = 1'b0;
                fail_d = 1'b0;
                fail_addr_d = '0;
                fail_elem_d = '0;
            end
            RUN: if (two_op && !ph_q) begin
                ph_d = 1'b1;
            end else if (!last_addr) begin
                addr_d = down ? addr_q - ONE : addr_q + ONE;
                ph_d = 1'b0;
            end else if (elem_q == 3'd5) begin
                state_d = DRAIN;
            end else begin
                elem_d = elem_q + 3'd1;
                addr_d = (elem_q == 3'd2 || elem_q == 3'd3) ? '1 : '0;
                ph_d = 1'b0;
            end
            DRAIN: state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (mism && STOP_ON_FAIL) state_d = DONE;
        run = state_d == RUN;
        rd = elem_d != 3'd0 && !ph_d;
        en_d = run || state_d == DRAIN;
        men_d = run;
        wen_d = run && !rd;
        ren_d = run && rd;
        baddr_d = run ? addr_d : '0;
        din_d = wen_d ? (elem_d[0] ? ~BG : BG) : '0;
        bm_d = run ? '1 : '0;
        chk_d = ren_q;
        exp_d = elem_q[0] ? BG : ~BG;
        chk_addr_d = baddr_q;
        chk_elem_d = elem_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            elem_q <= '0;
            addr_q <= '0;
            ph_q <= 1'b0;
            en_q <= 1'b0;
            men_q <= 1'b0;
            wen_q <= 1'b0;
            ren_q <= 1'b0;
            baddr_q <= '0;
            din_q <= '0;
            bm_q <= '0;
            chk_q <= 1'b0;
            exp_q <= '0;
            chk_addr_q <= '0;
            chk_elem_q <= '0;
            fail_q <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q <= elem_d;
            addr_q <= addr_d;
            ph_q <= ph_d;
            en_q <= en_d;
            men_q <= men_d;
            wen_q <= wen_d;
            ren_q <= ren_d;
            baddr_q <= baddr_d;
            din_q <= din_d;
            bm_q <= bm_d;
            chk_q <= chk_d;
            exp_q <= exp_d;
            chk_addr_q <= chk_addr_d;
            chk_elem_q <= chk_elem_d;
            fail_q <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end
    assign busy = state_q == RUN || state_q == DRAIN;
    assign done = state_q == DONE;
    assign fail = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign bist_en = en_q;
    assign bist_men = men_q;
    assign bist_wen = wen_q;
    assign bist_ren = ren_q;
    assign bist_addr = baddr_q;
    assign bist_din = din_q;
    assign bist_bm = bm_q;
endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb_sram_bist_ctrl: three controllers (plain, stop-on-fail, AA background) each on a behavioural 64x64 macro.
module tb_sram_bist_ctrl;
    logic clk, resetn;
    logic start_s[3], fault_en[3];
    logic busy_s[3], done_s[3], fail_s[3], en_s[3], men_s[3], wen_s[3], ren_s[3];
    logic [5:0] fail_addr_s[3], addr_s[3];
    logic [2:0] fail_elem_s[3];
    logic [63:0] din_s[3], bm_s[3];
    logic men_l[800], wen_l[800], ren_l[800], busy_l[800], done_l[800], fail_l[800], en_l[800];
    logic [5:0] addr_l[800];
    logic [63:0] din_l[800], bm_l[800];
    int n_cmp, n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam logic [63:0] BGV = (i == 2) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h0;
        logic [63:0] dout;
        logic [63:0] mem [64];
        sram_bist_ctrl #(.ADDR_W(6), .DATA_W(64), .BG(BGV), .STOP_ON_FAIL(i == 1)) u_dut (
            .clk(clk), .resetn(resetn), .start(start_s[i]),
            .busy(busy_s[i]), .done(done_s[i]), .fail(fail_s[i]),
            .fail_addr(fail_addr_s[i]), .fail_elem(fail_elem_s[i]),
            .bist_en(en_s[i]), .bist_men(men_s[i]), .bist_wen(wen_s[i]), .bist_ren(ren_s[i]),
            .bist_addr(addr_s[i]), .bist_din(din_s[i]), .bist_bm(bm_s[i]), .bist_dout(dout)
        );
        always @(posedge clk) begin
            if (men_s[i] && wen_s[i]) mem[addr_s[i]] <= (mem[addr_s[i]] & ~bm_s[i]) | (din_s[i] & bm_s[i]);
            if (men_s[i] && ren_s[i]) dout <= mem[addr_s[i]] | ((fault_en[i] && addr_s[i] == 6'h15) ? 64'h80 : 64'h0);
        end
    end

    typedef struct {
        int g;
        bit fault;
        int repulse;
        int ops;
        int done_cyc;
        int last_men;
        bit fail;
        logic [5:0] faddr;
        logic [2:0] felem;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [63:0] bg_of(input int g);
        return (g == 2) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle 1 is the cycle right after the start edge; outputs are sampled on the falling edge.
    task automatic run_test(input int g, input int repulse, output int ops, output int done_cyc, output int last_men);
        int cyc;
        @(negedge clk);
        start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
        cyc = 1;
        ops = 0;
        done_cyc = 0;
        last_men = 0;
        while (cyc < 800 && done_cyc == 0) begin
            men_l[cyc] = men_s[g];
            wen_l[cyc] = wen_s[g];
            ren_l[cyc] = ren_s[g];
            busy_l[cyc] = busy_s[g];
            done_l[cyc] = done_s[g];
            fail_l[cyc] = fail_s[g];
            en_l[cyc] = en_s[g];
            addr_l[cyc] = addr_s[g];
            din_l[cyc] = din_s[g];
            bm_l[cyc] = bm_s[g];
            if (men_s[g]) begin
                ops++;
                last_men = cyc;
            end
            if (done_s[g]) done_cyc = cyc;
            start_s[g] = (cyc == repulse);
            @(negedge clk);
            cyc++;
        end
        start_s[g] = 1'b0;
    endtask

    initial begin
        int ops, dc, lm;
        n_cmp = 0;
        n_bad = 0;
        resetn = 1'b0;
        for (int g = 0; g < 3; g++) begin
            start_s[g] = 1'b0;
            fault_en[g] = 1'b0;
        end
        vecs[0] = '{0, 1'b0, 0, 640, 642, 640, 1'b0, 6'h00, 3'd0};
        vecs[1] = '{0, 1'b1, 0, 640, 642, 640, 1'b1, 6'h15, 3'd1};
        vecs[2] = '{1, 1'b1, 0, 108, 109, 108, 1'b1, 6'h15, 3'd1};
        vecs[3] = '{2, 1'b0, 0, 640, 642, 640, 1'b0, 6'h00, 3'd0};
        vecs[4] = '{0, 1'b0, 50, 640, 642, 640, 1'b0, 6'h00, 3'd0};
        vecs[5] = '{1, 1'b0, 0, 640, 642, 640, 1'b0, 6'h00, 3'd0};
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_busy%0d", g), busy_s[g], 0);
            chk($sformatf("rst_done%0d", g), done_s[g], 0);
            chk($sformatf("rst_men%0d", g), men_s[g], 0);
            chk($sformatf("rst_en%0d", g), en_s[g], 0);
        end
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            fault_en[vecs[i].g] = vecs[i].fault;
            run_test(vecs[i].g, vecs[i].repulse, ops, dc, lm);
            chk($sformatf("v%0d_ops", i), ops, vecs[i].ops);
            chk($sformatf("v%0d_done_cyc", i), dc, vecs[i].done_cyc);
            chk($sformatf("v%0d_last_men", i), lm, vecs[i].last_men);
            chk($sformatf("v%0d_fail", i), fail_s[vecs[i].g], vecs[i].fail);
            chk($sformatf("v%0d_fail_addr", i), fail_addr_s[vecs[i].g], vecs[i].faddr);
            chk($sformatf("v%0d_fail_elem", i), fail_elem_s[vecs[i].g], vecs[i].felem);
            chk($sformatf("v%0d_c1_wen", i), {men_l[1], wen_l[1], ren_l[1], en_l[1], busy_l[1]}, 5'b11011);
            chk($sformatf("v%0d_c1_clr", i), {done_l[1], fail_l[1]}, 2'b00);
            chk($sformatf("v%0d_c1_addr", i), addr_l[1], 0);
            chk($sformatf("v%0d_c1_din", i), din_l[1], bg_of(vecs[i].g));
            chk($sformatf("v%0d_c1_bm", i), bm_l[1], 64'hFFFF_FFFF_FFFF_FFFF);
            if (dc > 0) begin
                chk($sformatf("v%0d_end_busy", i), {busy_l[dc], men_l[dc], en_l[dc], wen_l[dc], ren_l[dc]}, 0);
                chk($sformatf("v%0d_end_bus", i), {addr_l[dc], din_l[dc], bm_l[dc]}, 0);
            end
            if (vecs[i].ops == 640) begin
                chk($sformatf("v%0d_e1_write", i), {wen_l[66], addr_l[66]}, {1'b1, 6'd0});
                chk($sformatf("v%0d_e1_din", i), din_l[66], ~bg_of(vecs[i].g));
                chk($sformatf("v%0d_e3_first", i), {ren_l[321], addr_l[321]}, {1'b1, 6'd63});
                chk($sformatf("v%0d_e3_second", i), {ren_l[323], addr_l[323]}, {1'b1, 6'd62});
                chk($sformatf("v%0d_e3_last", i), {ren_l[447], addr_l[447]}, {1'b1, 6'd0});
            end
        end
        fault_en[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (299) @(negedge clk);
        chk("pre_rst_ops", {men_s[0], wen_s[0], busy_s[0]}, 3'b111);
        resetn = 1'b0;
        #1;
        chk("rst_mid_ctl", {men_s[0], wen_s[0], ren_s[0], en_s[0], busy_s[0], done_s[0], fail_s[0]}, 0);
        chk("rst_mid_bus", {addr_s[0], din_s[0], bm_s[0]}, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {busy_s[0], done_s[0], men_s[0], en_s[0]}, 0);
        run_test(0, 0, ops, dc, lm);
        chk("post_rst_ops", ops, 640);
        chk("post_rst_done", dc, 642);
        chk("post_rst_fail", fail_s[0], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
